// File: rtl/axis_bram_pkg.sv
// Shared types and sizing helpers for the AXIS BRAM stream master and its FIFO.
package axis_bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RUN  = 2'b10
  } state_t;

  // Ceiling log2, never below 1 so degenerate sizes still get a real vector.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // One FIFO entry holds {last, keep, data}.
  function automatic int entry_width(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/axis_bram_sfifo.sv
// Synchronous first-word-fall-through FIFO: dout shows the head entry whenever empty is low.
module axis_bram_sfifo
  import axis_bram_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16,
  localparam int AW = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_bram_stream_master.sv
// AXI4-Stream master draining a valid/ready user producer through a FWFT FIFO,
// with start delay, optional forced TLAST, and packet/level status.
module axis_bram_stream_master
  import axis_bram_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH         = 16,
  parameter int C_M_START_COUNT      = 32,
  parameter int C_MAX_PKT_LEN        = 0,
  parameter int C_PKT_CNT_WIDTH      = 16
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DIN_DATA,
  input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   DIN_KEEP,
  input  logic                                DIN_TLAST,
  input  logic                                DIN_VALID,
  output logic                                DIN_ACCEP,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic [C_PKT_CNT_WIDTH-1:0]          PKT_CNT,
  output logic [clogb2(C_FIFO_DEPTH):0]       FIFO_LEVEL,
  output logic                                BUSY
);

  localparam int DW     = C_M_AXIS_TDATA_WIDTH;
  localparam int KW     = DW / 8;
  localparam int EW     = entry_width(DW);
  localparam int WAIT_W = clogb2((C_M_START_COUNT > 2) ? C_M_START_COUNT : 2);
  localparam int BEAT_W = (C_MAX_PKT_LEN > 0) ? clogb2(C_MAX_PKT_LEN) + 1 : 16;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [EW-1:0]     fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              force_last;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        state_nxt    = (C_M_START_COUNT == 0) ? RUN : WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (wait_cnt == WAIT_W'(C_M_START_COUNT - 1)) state_nxt = RUN;
        else wait_cnt_nxt = wait_cnt + 1'b1;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept depends only on registered state, never on TREADY or DIN_VALID.
  assign DIN_ACCEP = (state == RUN) && !fifo_full;
  assign push      = DIN_VALID && DIN_ACCEP;
  assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;

  axis_bram_sfifo #(
    .WIDTH (EW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .push  (push),
    .pop   (pop),
    .din   ({DIN_TLAST, DIN_KEEP, DIN_DATA}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (FIFO_LEVEL)
  );

  assign force_last    = (C_MAX_PKT_LEN > 0) && (beat_cnt == BEAT_W'(C_MAX_PKT_LEN - 1));
  assign M_AXIS_TVALID = !fifo_empty;
  // Payload is zeroed while idle so reset drives every output low immediately.
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? fifo_dout[DW-1:0] : '0;
  assign M_AXIS_TKEEP  = M_AXIS_TVALID ? fifo_dout[DW+KW-1:DW] : '0;
  assign M_AXIS_TSTRB  = M_AXIS_TKEEP;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (fifo_dout[EW-1] || force_last);
  assign BUSY          = (FIFO_LEVEL != '0) || (beat_cnt != '0);

  // Beat counter saturates so an overlong unforced packet still reads as open.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      beat_cnt <= '0;
      PKT_CNT  <= '0;
    end else if (pop) begin
      if (M_AXIS_TLAST) begin
        beat_cnt <= '0;
        PKT_CNT  <= PKT_CNT + 1'b1;
      end else if (beat_cnt != {BEAT_W{1'b1}}) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_bram_stream_master.md
Name: axis_bram_stream_master

Overview:
Parametrised AXI4-Stream master that drains a user/BRAM-side producer into a standard AXIS port. It is the next generation of the team's AXIS master adapter and adds the following:
- a proper valid/ready handshake on the user side;
- an internal FIFO so TREADY backpressure never drops beats;
- a configurable start delay (zero allowed);
- an optional forced-TLAST packet length;
- TKEEP support;
- packet and level status outputs.

It sits between the BRAM read sequencer and the DMA S2MM stream input.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, data width in bits; multiple of 8, 8..512.
C_FIFO_DEPTH, 16, internal FIFO entries; power of 2, 2..1024.
C_M_START_COUNT, 32, cycles spent in WAIT after reset before accepting data; 0 skips WAIT.
C_MAX_PKT_LEN, 0, beats per packet after which TLAST is forced; 0 disables forcing.
C_PKT_CNT_WIDTH, 16, width of the packet counter.

Ports:
M_AXIS_ACLK  in  1  clock.
M_AXIS_ARESETN  in  1  reset; asynchronous assert, active-low.
DIN_DATA  in  C_M_AXIS_TDATA_WIDTH  user data.
DIN_KEEP  in  C_M_AXIS_TDATA_WIDTH/8  user byte-enables.
DIN_TLAST  in  1  user end-of-packet.
DIN_VALID  in  1  user beat valid.
DIN_ACCEP  out  1  user-side ready; a beat transfers when DIN_VALID && DIN_ACCEP.
M_AXIS_TVALID  out  1  stream valid.
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
M_AXIS_TKEEP  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifier.
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  equals M_AXIS_TKEEP.
M_AXIS_TLAST  out  1  packet boundary.
M_AXIS_TREADY  in  1  sink ready.
PKT_CNT  out  C_PKT_CNT_WIDTH  completed packets; wraps.
FIFO_LEVEL  out  clogb2(C_FIFO_DEPTH)+1  current occupancy.
BUSY  out  1  high when FIFO is non-empty or a packet is open.

Behaviour:
- Clock and reset: one clock, M_AXIS_ACLK. Reset is asynchronous and active-low (M_AXIS_ARESETN). All registers clear on assertion; release is used synchronously.
- Reset values: all outputs are 0, including DIN_ACCEP, TVALID, TDATA, TKEEP, TLAST, PKT_CNT, FIFO_LEVEL and BUSY. The FIFO is empty and the state is IDLE.
- State machine:
  - IDLE: always goes to WAIT next cycle, or to RUN if C_M_START_COUNT=0.
  - WAIT: counter runs from 0; at count==C_M_START_COUNT-1 go to RUN.
  - RUN: terminal until reset. There is no return to IDLE on TLAST.
- DIN_ACCEP = (state==RUN) && !fifo_full. It is registered-path only, with no combinational dependence on M_AXIS_TREADY or DIN_VALID.
- Push: when DIN_VALID && DIN_ACCEP, write {DIN_TLAST, DIN_KEEP, DIN_DATA} to the FIFO.
- Output timing: first-word-fall-through with one-cycle latency. A beat pushed into an empty FIFO at edge N appears on TVALID after edge N, so TVALID is high in cycle N+1.
- TVALID rules:
  - TVALID = fifo not empty.
  - TDATA, TKEEP and TLAST are stable while TVALID && !TREADY.
  - TVALID never deasserts without a handshake.
- Pop: M_AXIS_TVALID && M_AXIS_TREADY.
- Simultaneous push and pop: allowed when not full; level is unchanged. When full, push is blocked that cycle even if a pop occurs, because ACCEP was already low.
- Forced TLAST:
  - A beat counter counts output handshakes, resets to 0 after any beat with TLAST, and is C_MAX_PKT_LEN wide plus margin.
  - If C_MAX_PKT_LEN>0 and the counter == C_MAX_PKT_LEN-1, M_AXIS_TLAST=1 regardless of the stored last bit.
  - A stored last bit on an earlier beat ends the packet normally.
- PKT_CNT increments by 1 on each handshake with M_AXIS_TLAST=1 and wraps modulo 2^C_PKT_CNT_WIDTH.
- FIFO_LEVEL ranges 0..C_FIFO_DEPTH; full when it equals C_FIFO_DEPTH. Read and write pointers use clogb2(C_FIFO_DEPTH) bits and wrap naturally.
- BUSY = (FIFO_LEVEL!=0) || (beat counter!=0).
- DIN_KEEP is passed through unmodified; all-zero keep beats are forwarded as is.
- Reset mid-packet: FIFO contents, beat counter and PKT_CNT are discarded. The sink sees TVALID drop asynchronously, and the state restarts at IDLE.

Decomposition:
- Package axis_bram_pkg:
  - clogb2 function;
  - state encoding IDLE=2'b00, WAIT=2'b01, RUN=2'b10;
  - FIFO entry width helper (DATA+KEEP+1).
- One sub-module, axis_bram_sfifo: a parametrised width/depth synchronous first-word-fall-through FIFO with the same async reset. It provides push, pop, dout, empty, full and level.
- The top holds the state machine, beat/packet counters and TLAST forcing.

Test Plan:
- Start delay: defaults; DIN_VALID held high from reset release. DIN_ACCEP first goes high exactly 33 cycles after release (1 IDLE + 32 WAIT); with C_M_START_COUNT=0 it goes high after 1 cycle.
- Streaming: TREADY=1; push 8 beats 0x00000001..0x00000008 with TLAST on beat 8. The identical sequence appears on TDATA with 1-cycle latency, TLAST on 0x00000008, PKT_CNT=1, FIFO_LEVEL≤1.
- Backpressure/full: C_FIFO_DEPTH=4, TREADY=0, push 6 beats. 4 accepted, FIFO_LEVEL=4, DIN_ACCEP=0, TDATA held at beat 1. Then TREADY=1: all 6 beats emerge in order with no loss or duplication.
- Random stall: TREADY toggles randomly for 1000 beats in packets of random length 1..17. Scoreboard matches data, keep and last; PKT_CNT equals the number of packets sent; TDATA is never changed while TVALID && !TREADY.
- Forced TLAST: C_MAX_PKT_LEN=4; push 10 beats with no DIN_TLAST. TLAST is asserted on output beats 4 and 8; PKT_CNT=2; BUSY=1 with beat counter=2 after the stream ends.
- Reset mid-operation: assert ARESETN=0 with FIFO_LEVEL=3 mid-packet. All outputs go 0 in the same cycle without waiting for a clock edge. After release, re-run the streaming test; nothing stale is output and PKT_CNT counts from 0.
